// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard sequencer.
package hazard_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_LAST = 2'd2
   } hs_state_e;

   localparam int MUL_CYCLES_DEF = 4;
   localparam int CNT_W_DEF      = 16;
   localparam int MCNT_W         = 4;

endpackage

// File: rtl/hazard_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && (cnt_q != {W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_sequencer.sv
// Stall/flush control for a 5-stage pipeline: multi-cycle MUL freeze,
// load-use interlock and taken-branch flush, plus stall/flush counters.
module hazard_sequencer
   import hazard_pkg::*;
#(
   parameter int MUL_CYCLES = MUL_CYCLES_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       Rs1_i,
   input  logic [4:0]       Rs2_i,
   input  logic             MemRead_ex_i,
   input  logic [4:0]       Rd_ex_i,
   input  logic             MulEx_i,
   input  logic             BranchTaken_i,
   output logic             PCWrite_o,
   output logic             IFIDWrite_o,
   output logic             IDEXWrite_o,
   output logic             IDEXBubble_o,
   output logic             EXMEMBubble_o,
   output logic             IFFlush_o,
   output logic [CNT_W-1:0] StallCnt_o,
   output logic [CNT_W-1:0] FlushCnt_o
);

   hs_state_e         state_d, state_q;
   logic [MCNT_W-1:0] mcnt_d, mcnt_q;
   logic              freeze, loaduse;

   assign freeze  = (state_q == MUL_BUSY) || ((state_q == RUN) && MulEx_i);
   assign loaduse = MemRead_ex_i && (Rd_ex_i != 5'd0) &&
                    ((Rd_ex_i == Rs1_i) || (Rd_ex_i == Rs2_i));

   // The RUN cycle that sees MulEx_i is the first freeze cycle, so the
   // busy phase only needs MUL_CYCLES-2 more cycles (mcnt counts to 0).
   always_comb begin
      state_d = state_q;
      mcnt_d  = mcnt_q;
      unique case (state_q)
         RUN: begin
            if (MulEx_i) begin
               if (MUL_CYCLES == 2) begin
                  state_d = MUL_LAST;
               end else begin
                  state_d = MUL_BUSY;
                  mcnt_d  = MCNT_W'(MUL_CYCLES - 3);
               end
            end
         end
         MUL_BUSY: begin
            if (mcnt_q == '0) state_d = MUL_LAST;
            else              mcnt_d  = mcnt_q - 1'b1;
         end
         MUL_LAST: state_d = RUN;
         default:  state_d = RUN;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= RUN;
         mcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         mcnt_q  <= mcnt_d;
      end
   end

   always_comb begin
      PCWrite_o     = 1'b1;
      IFIDWrite_o   = 1'b1;
      IDEXWrite_o   = 1'b1;
      IDEXBubble_o  = 1'b0;
      EXMEMBubble_o = 1'b0;
      IFFlush_o     = 1'b0;
      if (rst_i) begin
         PCWrite_o     = 1'b0;
         IFIDWrite_o   = 1'b0;
         IDEXWrite_o   = 1'b0;
         IDEXBubble_o  = 1'b1;
         EXMEMBubble_o = 1'b1;
      end else if (freeze) begin
         PCWrite_o     = 1'b0;
         IFIDWrite_o   = 1'b0;
         IDEXWrite_o   = 1'b0;
         EXMEMBubble_o = 1'b1;
      end else if (loaduse) begin
         PCWrite_o     = 1'b0;
         IFIDWrite_o   = 1'b0;
         IDEXBubble_o  = 1'b1;
      end else if (BranchTaken_i) begin
         IFFlush_o     = 1'b1;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (1'b0),
      .inc_i (~PCWrite_o),
      .cnt_o (StallCnt_o)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (1'b0),
      .inc_i (IFFlush_o),
      .cnt_o (FlushCnt_o)
   );

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench: one instance with MUL_CYCLES=4, one with MUL_CYCLES=2, shared stimulus.
module tb_hazard_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  rs1, rs2, rd_ex;
   logic        memrd, mulex, br;

   logic        pcw_a, ifid_a, idex_a, idb_a, exb_a, ffl_a;
   logic        pcw_b, ifid_b, idex_b, idb_b, exb_b, ffl_b;
   logic [15:0] stall_a, flush_a, stall_b, flush_b;
   logic [5:0]  oa, ob;

   int n_chk  = 0;
   int n_fail = 0;

   // {PCWrite, IFIDWrite, IDEXWrite, IDEXBubble, EXMEMBubble, IFFlush}
   localparam logic [5:0] O_RST    = 6'b000110;
   localparam logic [5:0] O_NORM   = 6'b111000;
   localparam logic [5:0] O_LDUSE  = 6'b001100;
   localparam logic [5:0] O_FREEZE = 6'b000010;
   localparam logic [5:0] O_BRANCH = 6'b111001;

   always #5 clk = ~clk;

   assign oa = {pcw_a, ifid_a, idex_a, idb_a, exb_a, ffl_a};
   assign ob = {pcw_b, ifid_b, idex_b, idb_b, exb_b, ffl_b};

   hazard_sequencer #(.MUL_CYCLES(4), .CNT_W(16)) u_dut_a (
      .clk_i(clk), .rst_i(rst), .Rs1_i(rs1), .Rs2_i(rs2),
      .MemRead_ex_i(memrd), .Rd_ex_i(rd_ex), .MulEx_i(mulex), .BranchTaken_i(br),
      .PCWrite_o(pcw_a), .IFIDWrite_o(ifid_a), .IDEXWrite_o(idex_a),
      .IDEXBubble_o(idb_a), .EXMEMBubble_o(exb_a), .IFFlush_o(ffl_a),
      .StallCnt_o(stall_a), .FlushCnt_o(flush_a)
   );

   hazard_sequencer #(.MUL_CYCLES(2), .CNT_W(16)) u_dut_b (
      .clk_i(clk), .rst_i(rst), .Rs1_i(rs1), .Rs2_i(rs2),
      .MemRead_ex_i(memrd), .Rd_ex_i(rd_ex), .MulEx_i(mulex), .BranchTaken_i(br),
      .PCWrite_o(pcw_b), .IFIDWrite_o(ifid_b), .IDEXWrite_o(idex_b),
      .IDEXBubble_o(idb_b), .EXMEMBubble_o(exb_b), .IFFlush_o(ffl_b),
      .StallCnt_o(stall_b), .FlushCnt_o(flush_b)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      memrd = 1'b0; rd_ex = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
      mulex = 1'b0; br = 1'b0;
   endtask

   task automatic set_lu(input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2);
      memrd = 1'b1; rd_ex = rd; rs1 = s1; rs2 = s2;
   endtask

   initial begin
      rst = 1'b1;
      idle();

      // reset state
      @(negedge clk);
      chk("rst_out_a", 32'(oa), 32'(O_RST));
      chk("rst_out_b", 32'(ob), 32'(O_RST));
      chk("rst_stall_a", 32'(stall_a), 32'd0);
      chk("rst_flush_a", 32'(flush_a), 32'd0);
      nxt();
      rst = 1'b0;
      @(negedge clk);
      chk("idle_out_a", 32'(oa), 32'(O_NORM));
      nxt();

      // load-use on Rs2
      set_lu(5'd5, 5'd3, 5'd5);
      @(negedge clk);
      chk("lu_out_a", 32'(oa), 32'(O_LDUSE));
      nxt();
      idle();
      @(negedge clk);
      chk("lu_stall_a", 32'(stall_a), 32'd1);
      chk("lu_after_out_a", 32'(oa), 32'(O_NORM));
      nxt();

      // load to x0 never stalls
      set_lu(5'd0, 5'd0, 5'd0);
      @(negedge clk);
      chk("x0_out_a", 32'(oa), 32'(O_NORM));
      nxt();
      idle();
      @(negedge clk);
      chk("x0_stall_a", 32'(stall_a), 32'd1);
      nxt();

      // taken branch
      br = 1'b1;
      @(negedge clk);
      chk("br_out_a", 32'(oa), 32'(O_BRANCH));
      nxt();
      idle();
      @(negedge clk);
      chk("br_flush_a", 32'(flush_a), 32'd1);
      nxt();

      // MUL held 4 cycles: A freezes cycles 1-3, B freezes cycles 1 and 3
      mulex = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk($sformatf("mul4_out_a_c%0d", i + 1), 32'(oa), 32'((i < 3) ? O_FREEZE : O_NORM));
         chk($sformatf("mul4_out_b_c%0d", i + 1), 32'(ob), 32'((i % 2 == 0) ? O_FREEZE : O_NORM));
         nxt();
      end
      idle();
      @(negedge clk);
      chk("mul4_stall_a", 32'(stall_a), 32'd4);
      chk("mul4_stall_b", 32'(stall_b), 32'd3);
      nxt();

      // B: MUL 2 cycles with branch in MUL_LAST; A stays frozen
      mulex = 1'b1;
      @(negedge clk);
      chk("mul2_c1_b", 32'(ob), 32'(O_FREEZE));
      nxt();
      br = 1'b1;
      @(negedge clk);
      chk("mul2_last_br_b", 32'(ob), 32'(O_BRANCH));
      chk("busy_ignores_br_a", 32'(oa), 32'(O_FREEZE));
      nxt();
      idle();
      @(negedge clk);
      chk("busy_no_mulex_a", 32'(oa), 32'(O_FREEZE));
      chk("mul2_flush_b", 32'(flush_b), 32'd2);
      nxt();
      @(negedge clk);
      chk("mul_last_a", 32'(oa), 32'(O_NORM));
      nxt();

      // freeze beats load-use and branch; flush count must not move
      mulex = 1'b1; br = 1'b1; set_lu(5'd7, 5'd7, 5'd1);
      @(negedge clk);
      chk("prio_out_a", 32'(oa), 32'(O_FREEZE));
      nxt();
      idle();
      nxt();
      nxt();
      // A now in MUL_LAST: load-use still evaluated
      set_lu(5'd9, 5'd9, 5'd2);
      @(negedge clk);
      chk("last_lu_a", 32'(oa), 32'(O_LDUSE));
      nxt();
      idle();
      @(negedge clk);
      chk("prio_flush_a", 32'(flush_a), 32'd1);
      chk("prio_stall_a", 32'(stall_a), 32'd11);
      nxt();

      // reset in MUL_BUSY aborts the sequence
      mulex = 1'b1;
      nxt();
      mulex = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_out_a", 32'(oa), 32'(O_RST));
      chk("midrst_stall_a", 32'(stall_a), 32'd0);
      chk("midrst_flush_a", 32'(flush_a), 32'd0);
      nxt();
      rst = 1'b0;
      @(negedge clk);
      chk("postrst_out_a", 32'(oa), 32'(O_NORM));
      chk("postrst_stall_a", 32'(stall_a), 32'd0);
      nxt();

      // saturation: 65534 stall cycles to reach 0xFFFE, three more to pin at 0xFFFF
      set_lu(5'd4, 5'd4, 5'd0);
      repeat (65534) @(posedge clk);
      @(negedge clk);
      chk("sat_fffe_a", 32'(stall_a), 32'h0000_FFFE);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("sat_ffff_a", 32'(stall_a), 32'h0000_FFFF);
      idle();
      nxt();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
